uvw_rle_encoder: RTL and testbench
==================================

# uvw_rle_encoder

Downstream consumer of `neighboring_module`'s registered outputs `u`, `v` and `w`. It treats them as a 3-bit symbol stream and run-length encodes that stream. Each run of identical symbols becomes one record `{sym, run}`, which is buffered in a small FIFO and drained by a valid/ready consumer. The block sits directly behind `neighboring_module` in `paper_ex` and makes the stage's output trace observable without a per-cycle capture.

## Interface
Parameters:
- `RUN_W`, default 5: run-counter width; maximum run `RUN_MAX` = 2^RUN_W − 1.
- `DEPTH`, default 4: record FIFO depth, a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sample enable; `{u,v,w}` is consumed on cycles where `en`=1.
- `u`, `v`, `w`  in  1 each  symbol bits; `sym = {u,v,w}`.
- `flush`  in  1  close the open run now.
- `rec_valid`  out  1  record available at FIFO head.
- `rec_ready`  in  1  consumer accepts the head record.
- `rec_sym`  out  3  head record symbol.
- `rec_run`  out  RUN_W  head record run length, 1..RUN_MAX.
- `overflow`  out  1  sticky; a record was dropped because the FIFO was full.
- `drop_cnt`  out  8  saturating count of dropped records.

## Operation
- State machine: IDLE (no open run) and RUN (open run held in `cur_sym` and `cur_cnt`).
- **IDLE:**
  - `en`=1 opens a run: `cur_sym`=sample, `cur_cnt`=1, go to RUN.
  - `flush` alone does nothing.
- **RUN, `en`=1, `flush`=0:**
  - Sample equals `cur_sym` and `cur_cnt` < RUN_MAX: `cur_cnt`++.
  - Otherwise, covering both a symbol change and `cur_cnt`==RUN_MAX: push `{cur_sym,cur_cnt}` and open a new run with the sample, count 1.
- **RUN, `flush`=1:** push `{cur_sym,cur_cnt}` and go to IDLE.
  - `flush` has priority over `en`; a sample presented in a flush cycle is discarded.
- **Push:**
  - Accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the record is dropped: `overflow`←1 and `drop_cnt`++, saturating at 255.
- **Pop:** occurs when `rec_valid` && `rec_ready`.
- **Encoder independence:** the encoder never stalls on backpressure. Sampling continues; only records are lost.
- **Bit order:** `u` is the MSB of `sym`.

## Timing
- **Reset values:** state IDLE, FIFO empty, `rec_valid`=0, `rec_sym`=0, `rec_run`=0, `overflow`=0, `drop_cnt`=0.
  - Reset takes effect asynchronously; outputs change without waiting for `clk`.
- **Latency:** a record pushed at edge N is at the FIFO head with `rec_valid`=1 after edge N if the FIFO was empty.
- **Output stability:** `rec_sym` and `rec_run` are driven from the FIFO head and hold stable while `rec_valid`=1 and `rec_ready`=0.
- **Reset mid-operation:** the open run and all FIFO contents are discarded; nothing is emitted for them.
- **Full and pop in the same cycle:** the push is accepted, occupancy is unchanged, and `overflow` is not set.
- **Empty and push in the same cycle:** the record is visible the next cycle; there is no same-cycle bypass.
- **`overflow`:** cleared only by `rst`.
- **Pointers:** log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH; full/empty is decided by comparing the MSB and the remaining bits.

## Structure
- Package `uvw_rle_pkg`:
  - `sym_t` (3-bit symbol);
  - `rle_rec_t` struct `{sym_t sym; logic [RUN_W-1:0] run;}`;
  - state enum `{IDLE, RUN}`;
  - `DROP_MAX`=255.
- Sub-module `rle_fifo`: synchronous FIFO of `rle_rec_t`, parameterised by `DEPTH`, with `push`/`full`/`pop`/`empty` and async active-high reset.
- Top level: encoder FSM, run counter, drop counter, and one `rle_fifo` instance.

## Test plan
- **Basic run:** reset, `en`=1, `rec_ready`=1; sym 3'b101 for 3 cycles, then 3'b010 → one record {101,3}, with `rec_valid` high for one cycle, the cycle after the first 010 sample.
- **Saturation:** 3'b111 for 33 cycles, then `flush` → records {111,31} and {111,2}, in order; state returns to IDLE.
- **Backpressure and drop:** `rec_ready`=0, alternate 000/001 for 7 cycles, then `flush` → FIFO holds {000,1},{001,1},{000,1},{001,1}; `overflow`=1, `drop_cnt`=3.
- **Full with pop:** FIFO full and a run closes in the same cycle as `rec_ready`=1 → the head pops, the new record is queued, `overflow` stays 0, and occupancy remains 4.
- **Flush corner cases:** `flush` in IDLE → no record. `flush` with `en` and sym≠`cur_sym` → only the old run is emitted and the sample is discarded.
- **Asynchronous reset mid-traffic:** assert `rst` between clock edges with 2 records queued → `rec_valid`, `overflow` and `drop_cnt` go to 0 immediately, and no stale record appears after release.

Source files
------------

// File: rtl/uvw_rle_pkg.sv
// rtl/uvw_rle_pkg.sv - shared types and constants for the uvw run-length encoder
package uvw_rle_pkg;

  localparam int         RUN_W_DEF = 5;
  localparam logic [7:0] DROP_MAX  = 8'd255;

  typedef logic [2:0] sym_t;

  // Record at the default run width; the top rebuilds it for other RUN_W values.
  typedef struct packed {
    sym_t                 sym;
    logic [RUN_W_DEF-1:0] run;
  } rle_rec_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/rle_fifo.sv
// rtl/rle_fifo.sv - record FIFO with extra-MSB pointers for full/empty detection
module rle_fifo
  import uvw_rle_pkg::*;
#(
  parameter type T     = rle_rec_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  output logic full,
  input  logic pop,
  output logic empty,
  output T     rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  T            mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so stale storage never reaches the outputs.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uvw_rle_encoder.sv
// rtl/uvw_rle_encoder.sv - run-length encoder of the {u,v,w} symbol stream into a record FIFO
module uvw_rle_encoder
  import uvw_rle_pkg::*;
#(
  parameter int RUN_W = RUN_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             u,
  input  logic             v,
  input  logic             w,
  input  logic             flush,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_sym,
  output logic [RUN_W-1:0] rec_run,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  typedef struct packed {
    sym_t             sym;
    logic [RUN_W-1:0] run;
  } rec_t;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_e           state_q, state_d;
  sym_t             cur_sym_q, cur_sym_d;
  logic [RUN_W-1:0] cur_cnt_q, cur_cnt_d;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;

  sym_t sample;
  logic push;
  rec_t push_rec;
  rec_t head;
  logic full;
  logic empty;
  logic pop;
  logic drop;

  assign sample   = {u, v, w};
  assign push_rec = '{sym: cur_sym_q, run: cur_cnt_q};

  // Flush wins over en; a sample offered alongside flush is discarded.
  always_comb begin
    state_d   = state_q;
    cur_sym_d = cur_sym_q;
    cur_cnt_d = cur_cnt_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !flush) begin
          state_d   = RUN;
          cur_sym_d = sample;
          cur_cnt_d = RUN_ONE;
        end
      end
      RUN: begin
        if (flush) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (en) begin
          if (sample == cur_sym_q && cur_cnt_q != RUN_MAX) begin
            cur_cnt_d = cur_cnt_q + RUN_ONE;
          end else begin
            push      = 1'b1;
            cur_sym_d = sample;
            cur_cnt_d = RUN_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop  = rec_valid && rec_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_sym_q  <= '0;
      cur_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_sym_q <= cur_sym_d;
      cur_cnt_q <= cur_cnt_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != DROP_MAX) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  rle_fifo #(
    .T     (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_rec),
    .full  (full),
    .pop   (pop),
    .empty (empty),
    .rdata (head)
  );

  assign rec_valid = !empty;
  assign rec_sym   = head.sym;
  assign rec_run   = head.run;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uvw_rle_encoder.sv
// tb/tb_uvw_rle_encoder.sv - scoreboard bench for uvw_rle_encoder
module tb_uvw_rle_encoder;

  localparam int RUN_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             u = 1'b0;
  logic             v = 1'b0;
  logic             w = 1'b0;
  logic             flush = 1'b0;
  logic             rec_ready = 1'b0;
  logic             rec_valid;
  logic [2:0]       rec_sym;
  logic [RUN_W-1:0] rec_run;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int         errors = 0;
  int         checks = 0;
  int         pops = 0;
  int         pops_base;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uvw_rle_encoder #(.RUN_W(RUN_W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .u         (u),
    .v         (v),
    .w         (w),
    .flush     (flush),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_sym   (rec_sym),
    .rec_run   (rec_run),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic [2:0] s, input logic f);
    en = e;
    {u, v, w} = s;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input logic [2:0] s, input logic [4:0] r);
    exp_q.push_back({s, r});
  endtask

  // Handshakes are sampled mid-cycle, before the edge that performs the pop.
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rec", 32'({rec_sym, rec_run}), 32'hFFFF_FFFF);
      end else begin
        check_eq("rec", 32'({rec_sym, rec_run}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #12;
    check_eq("rst_valid", 32'(rec_valid), 32'd0);
    check_eq("rst_sym", 32'(rec_sym), 32'd0);
    check_eq("rst_run", 32'(rec_run), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic run
    rec_ready = 1'b1;
    expect_rec(3'b101, 5'd3);
    repeat (3) cyc(1'b1, 3'b101, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    check_eq("basic_valid_rise", 32'(rec_valid), 32'd1);
    cyc(1'b1, 3'b010, 1'b0);
    check_eq("basic_valid_fall", 32'(rec_valid), 32'd0);
    expect_rec(3'b010, 5'd2);
    cyc(1'b0, 3'b000, 1'b1);
    repeat (2) cyc(1'b0, 3'b000, 1'b0);

    // saturation at RUN_MAX
    expect_rec(3'b111, 5'd31);
    expect_rec(3'b111, 5'd2);
    repeat (33) cyc(1'b1, 3'b111, 1'b0);
    cyc(1'b0, 3'b000, 1'b1);
    repeat (2) cyc(1'b0, 3'b000, 1'b0);
    repeat (2) cyc(1'b0, 3'b000, 1'b1);
    check_eq("idle_flush", 32'(rec_valid), 32'd0);

    // backpressure and drop
    rec_ready = 1'b0;
    for (int i = 0; i < 7; i++) cyc(1'b1, 3'(i % 2), 1'b0);
    cyc(1'b0, 3'b000, 1'b1);
    check_eq("bp_overflow", 32'(overflow), 32'd1);
    check_eq("bp_drop_cnt", 32'(drop_cnt), 32'd3);
    check_eq("bp_valid", 32'(rec_valid), 32'd1);
    cyc(1'b0, 3'b000, 1'b0);
    check_eq("bp_hold", 32'({rec_sym, rec_run}), 32'({3'b000, 5'd1}));
    expect_rec(3'b000, 5'd1);
    expect_rec(3'b001, 5'd1);
    expect_rec(3'b000, 5'd1);
    expect_rec(3'b001, 5'd1);
    rec_ready = 1'b1;
    repeat (2) cyc(1'b0, 3'b000, 1'b0);
    rec_ready = 1'b0;

    // asynchronous reset between edges with two records queued
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(rec_valid), 32'd0);
    check_eq("arst_overflow", 32'(overflow), 32'd0);
    check_eq("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rec_ready = 1'b1;
    repeat (3) cyc(1'b0, 3'b000, 1'b0);
    check_eq("arst_no_stale", 32'(rec_valid), 32'd0);

    // full FIFO with a push and a pop in the same cycle
    rec_ready = 1'b0;
    expect_rec(3'b010, 5'd1);
    expect_rec(3'b011, 5'd1);
    expect_rec(3'b010, 5'd1);
    expect_rec(3'b011, 5'd1);
    expect_rec(3'b010, 5'd1);
    cyc(1'b1, 3'b010, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    rec_ready = 1'b1;
    cyc(1'b1, 3'b011, 1'b0);
    rec_ready = 1'b0;
    check_eq("fullpop_overflow", 32'(overflow), 32'd0);
    check_eq("fullpop_drop_cnt", 32'(drop_cnt), 32'd0);
    cyc(1'b1, 3'b011, 1'b0);
    pops_base = pops;
    rec_ready = 1'b1;
    repeat (6) cyc(1'b0, 3'b000, 1'b0);
    check_eq("fullpop_occupancy", 32'(pops - pops_base), 32'd4);
    check_eq("fullpop_drained", 32'(rec_valid), 32'd0);
    expect_rec(3'b011, 5'd2);
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b0, 3'b000, 1'b0);

    // flush with a differing sample discards the sample
    expect_rec(3'b100, 5'd1);
    cyc(1'b1, 3'b100, 1'b0);
    cyc(1'b1, 3'b110, 1'b1);
    cyc(1'b0, 3'b000, 1'b0);
    cyc(1'b0, 3'b000, 1'b1);
    repeat (2) cyc(1'b0, 3'b000, 1'b0);
    check_eq("flush_discard", 32'(rec_valid), 32'd0);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
